// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl_if
//  Purpose  : Pipeline request and word-memory bus bundle for lsu_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_ctrl_if;
    logic        req;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    modport master (
        output req, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        input  busy, done, rdata, addr_err, mem_addr, mem_we, mem_wdata, mem_pc
    );

    modport slave (
        input  req, req_op, req_addr, req_wdata, req_pc, mem_rdata,
        output busy, done, rdata, addr_err, mem_addr, mem_we, mem_wdata, mem_pc
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : Load/store unit controller over a word-wide memory; sub-word
//             stores are done as read-modify-write.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset,
    lsu_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        addr_err_q, addr_err_d;

    logic        w_req_word, w_req_half, w_misaligned;
    logic [31:0] w_req_addr_clr;
    logic [31:0] w_lane, w_load_data;
    logic [31:0] w_lane_mask, w_merge_data, w_store_word;

    // Offending low bits are cleared up front; with alignment checking on,
    // only aligned requests ever reach the clearing path, so it is a no-op.
    always_comb begin
        w_req_word     = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
        w_req_half     = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH);
        w_misaligned   = (w_req_word && (bus.req_addr[1:0] != 2'b00)) ||
                         (w_req_half && bus.req_addr[0]);
        w_req_addr_clr = bus.req_addr;
        if (w_req_word) begin
            w_req_addr_clr[1:0] = 2'b00;
        end else if (w_req_half) begin
            w_req_addr_clr[0] = 1'b0;
        end
    end

    always_comb begin
        w_lane = bus.mem_rdata >> {addr_q[1:0], 3'b000};
        unique case (op_q)
            OP_LH:   w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            OP_LHU:  w_load_data = {16'h0000, w_lane[15:0]};
            OP_LB:   w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            OP_LBU:  w_load_data = {24'h000000, w_lane[7:0]};
            default: w_load_data = bus.mem_rdata;
        endcase
    end

    // Store data is replicated across all lanes so the mask alone picks the lane.
    always_comb begin
        if (op_q == OP_SH) begin
            w_lane_mask  = 32'h0000_FFFF << {addr_q[1], 4'b0000};
            w_merge_data = {2{wdata_q[15:0]}};
        end else begin
            w_lane_mask  = 32'h0000_00FF << {addr_q[1:0], 3'b000};
            w_merge_data = {4{wdata_q[7:0]}};
        end
        w_store_word = (op_q == OP_SW) ? wdata_q
                                       : ((buf_q & ~w_lane_mask) | (w_merge_data & w_lane_mask));
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        buf_d      = buf_q;
        rdata_d    = rdata_q;
        addr_err_d = addr_err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    op_d    = bus.req_op;
                    wdata_d = bus.req_wdata;
                    pc_d    = bus.req_pc;
                    if (CHECK_ALIGN && w_misaligned) begin
                        addr_d     = bus.req_addr;
                        rdata_d    = 32'h0;
                        addr_err_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        addr_d  = w_req_addr_clr;
                        state_d = (bus.req_op == OP_SW) ? WRITE : READ;
                    end
                end
            end
            READ: begin
                buf_d = bus.mem_rdata;
                if ((op_q == OP_SH) || (op_q == OP_SB)) begin
                    state_d = WRITE;
                end else begin
                    rdata_d    = w_load_data;
                    addr_err_d = 1'b0;
                    state_d    = DONE;
                end
            end
            WRITE: begin
                rdata_d    = 32'h0;
                addr_err_d = 1'b0;
                state_d    = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            pc_q       <= 32'h0;
            buf_q      <= 32'h0;
            rdata_q    <= 32'h0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            buf_q      <= buf_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.rdata     = rdata_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_wdata = w_store_word;
    assign bus.mem_pc    = pc_q;
endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Scoreboard bench for lsu_ctrl with a word-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3;
    localparam logic [2:0] LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    typedef struct { logic [31:0] rdata; logic err; bit has_rdata; int acc; int lat; } done_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [31:0] pc; } wr_exp_t;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_tot = 0;

    logic [31:0] mem     [64];
    logic [31:0] mem0    [64];
    logic [31:0] ref_mem [64];
    done_exp_t   done_q[$];
    wr_exp_t     wr_q[$];
    done_exp_t   de;
    wr_exp_t     we_e;

    always #5 clk = ~clk;

    lsu_ctrl_if bus ();
    lsu_ctrl_if bus0 ();

    lsu_ctrl #(.CHECK_ALIGN(1'b1)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
    lsu_ctrl #(.CHECK_ALIGN(1'b0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h8899AABB : 32'(32'h9E3779B9 * (i + 1));
    endfunction

    assign bus.mem_rdata  = mem[bus.mem_addr[7:2]];
    assign bus0.mem_rdata = mem0[bus0.mem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]  <= init_word(i);
                mem0[i] <= init_word(i);
            end
        end else begin
            if (bus.mem_we)  mem[bus.mem_addr[7:2]]   <= bus.mem_wdata;
            if (bus0.mem_we) mem0[bus0.mem_addr[7:2]] <= bus0.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference model: resolves one access against the shadow memory.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, input int acc);
        int k, h;
        logic [31:0] w, v;
        bit word, half;
        word = (op == LW) || (op == SW);
        half = (op == LH) || (op == LHU) || (op == SH);
        if ((word && (addr % 4 != 0)) || (half && (addr % 2 != 0))) begin
            done_q.push_back('{32'h0, 1'b1, 1'b1, acc, 1});
            return;
        end
        k = int'(addr % 4);
        h = k / 2;
        w = ref_mem[addr[7:2]];
        case (op)
            LB, LBU: begin
                v = (w >> (8 * k)) % 256;
                if (op == LB && v >= 128) v = v - 256;
            end
            LH, LHU: begin
                v = (w >> (16 * h)) % 65536;
                if (op == LH && v >= 32768) v = v - 65536;
            end
            SB: v = w - (((w >> (8 * k)) % 256) << (8 * k)) + ((wdata % 256) << (8 * k));
            SH: v = w - (((w >> (16 * h)) % 65536) << (16 * h)) + ((wdata % 65536) << (16 * h));
            SW: v = wdata;
            default: v = w;
        endcase
        if (op >= SW) begin
            ref_mem[addr[7:2]] = v;
            wr_q.push_back('{addr - 32'(k), v, pc});
            done_q.push_back('{32'h0, 1'b0, 1'b0, acc, (op == SW) ? 2 : 3});
        end else begin
            done_q.push_back('{v, 1'b0, 1'b1, acc, 2});
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                chk("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    de = done_q.pop_front();
                    chk("addr_err", 32'(bus.addr_err), 32'(de.err));
                    if (de.has_rdata) chk("rdata", bus.rdata, de.rdata);
                    chk("latency", 32'(cyc - de.acc + 1), 32'(de.lat));
                end
            end
            if (bus.mem_we) begin
                chk("write_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    we_e = wr_q.pop_front();
                    chk("mem_addr", bus.mem_addr, we_e.addr);
                    chk("mem_wdata", bus.mem_wdata, we_e.data);
                    chk("mem_pc", bus.mem_pc, we_e.pc);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] pc, input bit track);
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("issue_idle", 32'(bus.busy), 32'd0);
        bus.req       = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = pc;
        if (track) model(op, addr, wdata, pc, cyc + 1);
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((done_q.size() != 0 || wr_q.size() != 0 || bus.busy) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("pending_done", 32'(done_q.size()), 32'd0);
        chk("pending_write", 32'(wr_q.size()), 32'd0);
    endtask

    task automatic issue0(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err);
        int t = 0;
        @(negedge clk);
        bus0.req       = 1'b1;
        bus0.req_op    = op;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        bus0.req_pc    = 32'h0000_0C00;
        @(negedge clk);
        bus0.req = 1'b0;
        while (!bus0.done && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("dut0_done", 32'(bus0.done), 32'd1);
        rd  = bus0.rdata;
        err = bus0.addr_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, rd;
        logic        err;
        int          accepts, t;

        bus.req = 1'b0;  bus.req_op = 3'd0;  bus.req_addr = 32'h0;  bus.req_wdata = 32'h0;  bus.req_pc = 32'h0;
        bus0.req = 1'b0; bus0.req_op = 3'd0; bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0; bus0.req_pc = 32'h0;
        reset   = 1'b0;
        preload = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy",      32'(bus.busy), 32'd0);
        chk("rst_done",      32'(bus.done), 32'd0);
        chk("rst_addr_err",  32'(bus.addr_err), 32'd0);
        chk("rst_mem_we",    32'(bus.mem_we), 32'd0);
        chk("rst_rdata",     bus.rdata, 32'h0);
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_mem_pc",    bus.mem_pc, 32'h0);
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        preload = 1'b0;

        issue(LB,  32'h11, 32'h0, 32'h0000_0100, 1'b1);
        issue(LHU, 32'h12, 32'h0, 32'h0000_0104, 1'b1);
        issue(LH,  32'h12, 32'h0, 32'h0000_0108, 1'b1);
        issue(SB,  32'h13, 32'h12345677, 32'h0000_0A40, 1'b1);
        issue(SW,  32'h22, 32'hDEADBEEF, 32'h0000_0110, 1'b1);
        drain();
        chk("sb_word", mem[4], 32'h7799AABB);
        chk("misaligned_sw_no_write", mem[8], init_word(8));

        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (op == LW || op == SW) a = a - (a % 4);
                else if (op == LH || op == LHU || op == SH) a = a - (a % 2);
            end
            issue(op, a, $urandom(), $urandom(), 1'b1);
        end
        drain();

        // Back-to-back LW with req held high the whole time.
        accepts = 0;
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, 63) * 4);
            bus.req      = 1'b1;
            bus.req_op   = LW;
            bus.req_addr = a;
            bus.req_pc   = 32'h0000_2000 + 32'(i * 4);
            if (!bus.busy) begin
                model(LW, a, 32'h0, 32'h0000_2000 + 32'(i * 4), cyc + 1);
                accepts++;
            end
            @(negedge clk);
        end
        bus.req = 1'b0;
        chk("hold_accepts", 32'(accepts), 32'd4);
        drain();

        // Abort an SH while it is in its write cycle.
        issue(SH, 32'h32, 32'h0000_BEEF, 32'h0000_3000, 1'b0);
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (!bus.mem_we && t < 10);
        chk("abort_reached_write", 32'(bus.mem_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_busy",   32'(bus.busy), 32'd0);
        chk("abort_done",   32'(bus.done), 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'h0);
        @(posedge clk);
        #1;
        chk("abort_mem_unchanged", mem[12], ref_mem[12]);
        @(negedge clk);
        reset = 1'b0;
        issue(LW, 32'h30, 32'h0, 32'h0000_3004, 1'b1);
        issue(SH, 32'h32, 32'h0000_BEEF, 32'h0000_3008, 1'b1);
        drain();

        // Alignment checking disabled: offending bits are dropped.
        issue0(SW, 32'h22, 32'hCAFEF00D, rd, err);
        chk("noalign_sw_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("noalign_sw_mem", mem0[8], 32'hCAFEF00D);
        issue0(LH, 32'h13, 32'h0, rd, err);
        chk("noalign_lh_rdata", rd, 32'hFFFF8899);
        chk("noalign_lh_err", 32'(err), 32'd0);
        issue0(LW, 32'h23, 32'h0, rd, err);
        chk("noalign_lw_rdata", rd, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
`default_nettype wire
